// File: rtl/dmem_hs.sv
// Handshaked byte-addressed data memory with byte/halfword/word access, registered
// responses, misalignment/illegal-funct3 detection and a post-reset clear engine.
module dmem_hs #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [31:0]           resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  clear_busy_o
);
    localparam int unsigned IdxW  = ADDR_WIDTH - 2;
    localparam int unsigned Depth = 1 << IdxW;

    typedef enum logic {StClear, StRun} state_e;

    state_e          state_q;
    logic [IdxW-1:0] clr_idx_q;
    logic            clear_busy_q;
    logic            resp_valid_q;
    logic            resp_err_q;
    logic [31:0]     resp_rdata_q;
    logic [31:0]     mem_q [Depth];

    logic            accept;
    logic            legal;
    logic            misaligned;
    logic            req_err;
    logic            wr_en;
    logic [IdxW-1:0] word_idx;
    logic [1:0]      lane;
    logic [3:0]      be;
    logic [31:0]     wdata_rep;
    logic [31:0]     rd_word;
    logic [31:0]     rd_shift;
    logic [31:0]     load_data;

    always_comb begin
        word_idx    = req_addr_i[ADDR_WIDTH-1:2];
        lane        = req_addr_i[1:0];
        req_ready_o = (state_q == StRun) && !rst_i && (!resp_valid_q || resp_ready_i);
        accept      = req_valid_i && req_ready_o;

        // Stores allow only SB/SH/SW; loads additionally allow LBU/LHU.
        if (req_we_i) begin
            legal = !req_funct3_i[2] && (req_funct3_i[1:0] != 2'b11);
        end else begin
            legal = (req_funct3_i[1:0] != 2'b11) && !(req_funct3_i[2] && req_funct3_i[1]);
        end

        case (req_funct3_i[1:0])
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = |lane;
            default: misaligned = 1'b0;
        endcase

        req_err = !legal || misaligned;
        wr_en   = accept && req_we_i && !req_err;

        case (req_funct3_i[1:0])
            2'b00: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata_i[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = req_wdata_i;
            end
        endcase

        rd_word  = mem_q[word_idx];
        rd_shift = rd_word >> {lane, 3'b000};
        case (req_funct3_i)
            3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_data = {24'b0, rd_shift[7:0]};
            3'b101:  load_data = {16'b0, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= CLEAR_ON_RESET ? StClear : StRun;
            clr_idx_q    <= '0;
            clear_busy_q <= CLEAR_ON_RESET;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                StClear: begin
                    clr_idx_q <= clr_idx_q + IdxW'(1);
                    if (clr_idx_q == IdxW'(Depth - 1)) begin
                        state_q      <= StRun;
                        clear_busy_q <= 1'b0;
                    end
                end
                default: ;
            endcase

            // A new acceptance overwrites the slot even when the old response drains same edge.
            if (accept) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= req_err;
                resp_rdata_q <= (req_we_i || req_err) ? 32'd0 : load_data;
            end else if (resp_ready_i) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == StClear) begin
            mem_q[clr_idx_q] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign clear_busy_o = clear_busy_q;

endmodule

// File: tb/tb_dmem_hs.sv
// Bench for dmem_hs: byte-array reference model, directed scenarios and random
// back-to-back traffic.
module tb_dmem_hs;
    localparam int unsigned AW = 6;
    localparam int unsigned NB = 1 << AW;
    localparam int unsigned NW = NB / 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          clear_busy;

    int assertions = 0;
    int failures   = 0;

    logic [7:0] ref_mem [NB];

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        int          a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
    } op_t;

    dmem_hs #(
        .ADDR_WIDTH     (AW),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .clear_busy_o (clear_busy)
    );

    always #5 clk = ~clk;

    function automatic bit m_err(input logic we, input logic [2:0] f3, input int a);
        int size;
        if (f3[1:0] == 2'b11) return 1'b1;
        if (we && f3[2]) return 1'b1;
        if (!we && f3 == 3'b110) return 1'b1;
        size = 1 << f3[1:0];
        return (a % size) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input int a);
        int     size = 1 << f3[1:0];
        longint v    = 0;
        for (int i = size - 1; i >= 0; i--) v = v * 256 + longint'(ref_mem[a + i]);
        if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
            v = v - (longint'(1) << (8 * size));
        return v[31:0];
    endfunction

    task automatic model_op(input logic we, input logic [2:0] f3, input int a,
                            input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int size;
        er = m_err(we, f3, a);
        rd = 32'd0;
        if (!er) begin
            size = 1 << f3[1:0];
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8*i +: 8];
            end else begin
                rd = m_load(f3, a);
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NB; i++) ref_mem[i] = 8'h00;
    endtask

    function automatic op_t mk(input string nm, input logic we, input logic [2:0] f3, input int a,
                               input logic [31:0] wd, input logic [31:0] rd, input logic er);
        op_t o;
        o.name = nm; o.we = we; o.f3 = f3; o.a = a; o.wd = wd; o.rd = rd; o.er = er;
        return o;
    endfunction

    // Single request with resp_ready=1; returns what the response register shows after acceptance.
    task automatic access(input logic we, input logic [2:0] f3, input int a, input logic [31:0] wd,
                          output logic rv, output logic [31:0] rd, output logic er);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = AW'(a); req_wdata = wd;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        rv = resp_valid; rd = resp_rdata; er = resp_err;
    endtask

    task automatic wait_clear(input string nm);
        int n     = 0;
        int early = 0;
        while (clear_busy && n < 100) begin
            if (req_ready) early++;
            n++;
            @(negedge clk);
        end
        assertions++;
        if (n != NW || early != 0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s: busy_cycles=%0d ready_during_clear=%0d ready=%0b, want %0d 0 1",
                     nm, n, early, req_ready, NW);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        assertions++;
        if ({req_ready, resp_valid, resp_err, resp_rdata, clear_busy} !== {3'b000, 32'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_values: ready=%0b valid=%0b err=%0b rdata=%08h busy=%0b, want 0 0 0 0 1",
                     req_ready, resp_valid, resp_err, resp_rdata, clear_busy);
        end
    endtask

    task automatic test_clear();
        logic rv, er;
        logic [31:0] rd;
        rst = 1'b0;
        wait_clear("clear_duration");
        model_clear();
        access(1'b0, 3'b010, 'h3C, 32'd0, rv, rd, er);
        assertions++;
        if ({rv, er, rd} !== {1'b1, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL lw_after_clear: v=%0b err=%0b rdata=%08h, want 1 0 00000000", rv, er, rd);
        end
    endtask

    task automatic run_ops(input string tag, input op_t ops[$]);
        logic rv, er, mer;
        logic [31:0] rd, mrd;
        foreach (ops[i]) begin
            model_op(ops[i].we, ops[i].f3, ops[i].a, ops[i].wd, mrd, mer);
            access(ops[i].we, ops[i].f3, ops[i].a, ops[i].wd, rv, rd, er);
            assertions++;
            if ({rv, er, rd} !== {1'b1, ops[i].er, ops[i].rd}) begin
                failures++;
                $display("FAIL %s_%s: v=%0b err=%0b rdata=%08h, want v=1 err=%0b rdata=%08h",
                         tag, ops[i].name, rv, er, rd, ops[i].er, ops[i].rd);
            end
        end
    endtask

    task automatic test_lanes();
        op_t ops[$];
        ops.push_back(mk("sw",    1'b1, 3'b010, 'h10, 32'h11223344, 32'd0,        1'b0));
        ops.push_back(mk("sb",    1'b1, 3'b000, 'h11, 32'h000000AA, 32'd0,        1'b0));
        ops.push_back(mk("sh",    1'b1, 3'b001, 'h12, 32'h0000BEEF, 32'd0,        1'b0));
        ops.push_back(mk("lw",    1'b0, 3'b010, 'h10, 32'd0,        32'hBEEFAA44, 1'b0));
        run_ops("lanes", ops);
    endtask

    task automatic test_extension();
        op_t ops[$];
        ops.push_back(mk("sw",  1'b1, 3'b010, 'h10, 32'h80FF7F01, 32'd0,        1'b0));
        ops.push_back(mk("lb",  1'b0, 3'b000, 'h12, 32'd0,        32'hFFFFFFFF, 1'b0));
        ops.push_back(mk("lbu", 1'b0, 3'b100, 'h13, 32'd0,        32'h00000080, 1'b0));
        ops.push_back(mk("lh",  1'b0, 3'b001, 'h12, 32'd0,        32'hFFFF80FF, 1'b0));
        ops.push_back(mk("lhu", 1'b0, 3'b101, 'h10, 32'd0,        32'h00007F01, 1'b0));
        run_ops("ext", ops);
    endtask

    task automatic test_errors();
        op_t ops[$];
        ops.push_back(mk("sh_mis",   1'b1, 3'b001, 'h11, 32'h0000DEAD, 32'd0,        1'b1));
        ops.push_back(mk("lw_same",  1'b0, 3'b010, 'h10, 32'd0,        32'h80FF7F01, 1'b0));
        ops.push_back(mk("lw_mis",   1'b0, 3'b010, 'h12, 32'd0,        32'd0,        1'b1));
        ops.push_back(mk("ld_f3_3",  1'b0, 3'b011, 'h10, 32'd0,        32'd0,        1'b1));
        ops.push_back(mk("st_f3_3",  1'b1, 3'b011, 'h10, 32'hFFFFFFFF, 32'd0,        1'b1));
        ops.push_back(mk("st_f3_4",  1'b1, 3'b100, 'h10, 32'h000000EE, 32'd0,        1'b1));
        ops.push_back(mk("lhu_mis",  1'b0, 3'b101, 'h13, 32'd0,        32'd0,        1'b1));
        ops.push_back(mk("ld_f3_6",  1'b0, 3'b110, 'h10, 32'd0,        32'd0,        1'b1));
        ops.push_back(mk("lw_still", 1'b0, 3'b010, 'h10, 32'd0,        32'h80FF7F01, 1'b0));
        run_ops("err", ops);
    endtask

    task automatic test_backpressure();
        logic rv, er;
        logic [31:0] rd, e0, e1, e2;
        logic [31:0] dummy;
        logic de;
        model_op(1'b1, 3'b010, 'h14, 32'h0A0B0C0D, dummy, de);
        access(1'b1, 3'b010, 'h14, 32'h0A0B0C0D, rv, rd, er);
        model_op(1'b1, 3'b010, 'h18, 32'h55667788, dummy, de);
        access(1'b1, 3'b010, 'h18, 32'h55667788, rv, rd, er);
        e0 = m_load(3'b010, 'h10);
        e1 = m_load(3'b010, 'h14);
        e2 = m_load(3'b010, 'h18);

        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = AW'('h10);
        @(negedge clk);
        req_addr = AW'('h14);
        for (int i = 0; i < 3; i++) begin
            assertions++;
            if ({resp_valid, resp_err, resp_rdata, req_ready} !== {1'b1, 1'b0, e0, 1'b0}) begin
                failures++;
                $display("FAIL stall_%0d: v=%0b err=%0b rdata=%08h ready=%0b, want 1 0 %08h 0",
                         i, resp_valid, resp_err, resp_rdata, req_ready, e0);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        assertions++;
        if ({resp_valid, resp_rdata} !== {1'b1, e1}) begin
            failures++;
            $display("FAIL drain_1: v=%0b rdata=%08h, want 1 %08h", resp_valid, resp_rdata, e1);
        end
        req_addr = AW'('h18);
        @(negedge clk);
        req_valid = 1'b0;
        assertions++;
        if ({resp_valid, resp_rdata} !== {1'b1, e2}) begin
            failures++;
            $display("FAIL drain_2: v=%0b rdata=%08h, want 1 %08h", resp_valid, resp_rdata, e2);
        end
        @(negedge clk);
        assertions++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty: v=%0b, want 0", resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 150;
        logic [31:0] exp_rd[$];
        logic        exp_er[$];
        logic [31:0] mrd, wd, erd;
        logic        mer, we, eer;
        logic [2:0]  f3;
        int          a;
        int          last_a = 0;
        @(negedge clk);
        for (int i = 0; i <= N; i++) begin
            if (i > 0) begin
                erd = exp_rd.pop_front();
                eer = exp_er.pop_front();
                assertions++;
                if ({resp_valid, resp_err, resp_rdata} !== {1'b1, eer, erd}) begin
                    failures++;
                    $display("FAIL b2b_%0d: v=%0b err=%0b rdata=%08h, want 1 %0b %08h",
                             i - 1, resp_valid, resp_err, resp_rdata, eer, erd);
                end
            end
            if (i < N) begin
                assertions++;
                if (req_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready_%0d: ready=%0b, want 1", i, req_ready);
                end
                we = 1'($urandom_range(0, 1));
                f3 = 3'($urandom_range(0, 7));
                wd = $urandom;
                if ($urandom_range(0, 1) == 1) a = (last_a & ~3) + int'($urandom_range(0, 3));
                else a = int'($urandom_range(0, NB - 1));
                last_a = a;
                model_op(we, f3, a, wd, mrd, mer);
                exp_rd.push_back(mrd);
                exp_er.push_back(mer);
                req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = AW'(a); req_wdata = wd;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic rv, er, de;
        logic [31:0] rd, dummy;
        model_op(1'b1, 3'b010, 'h20, 32'hCAFEF00D, dummy, de);
        access(1'b1, 3'b010, 'h20, 32'hCAFEF00D, rv, rd, er);
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = AW'('h20);
        @(negedge clk);
        req_valid = 1'b0;
        assertions++;
        if ({resp_valid, resp_rdata} !== {1'b1, 32'hCAFEF00D}) begin
            failures++;
            $display("FAIL pre_reset_resp: v=%0b rdata=%08h, want 1 cafef00d", resp_valid, resp_rdata);
        end
        #2 rst = 1'b1;
        #1;
        assertions++;
        if ({resp_valid, req_ready, clear_busy, resp_rdata} !== {3'b001, 32'd0}) begin
            failures++;
            $display("FAIL async_reset: v=%0b ready=%0b busy=%0b rdata=%08h, want 0 0 1 0",
                     resp_valid, req_ready, clear_busy, resp_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        resp_ready = 1'b1;
        wait_clear("reclear_duration");
        model_clear();
        for (int w = 0; w < NW; w++) begin
            access(1'b0, 3'b010, w * 4, 32'd0, rv, rd, er);
            assertions++;
            if ({rv, er, rd} !== {1'b1, 1'b0, m_load(3'b010, w * 4)}) begin
                failures++;
                $display("FAIL reclear_word_%0d: v=%0b err=%0b rdata=%08h, want 1 0 00000000",
                         w, rv, er, rd);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_clear();
        test_lanes();
        test_extension();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
